// File: rtl/vga_capture.sv
// vga_capture: pixel grabber for a positive-sync VGA stream, one pixel per clock.
//
// The incoming colour and sync lines are registered once (stage 1). Horizontal
// and vertical counters are derived from the stage-1 sync edges. A small FSM
// locks onto a stream only after a whole frame with the expected timing. Active
// pixels are then forwarded with their coordinates through a second register
// stage (stage 2). The pixel sampled in cycle n appears on pix_data in cycle n+2.
//
// Ports:
//   CLOCK_50                  in   pixel clock, rising edge
//   reset                     in   asynchronous, active-high
//   VGA_R/VGA_G/VGA_B         in   colour channels, PIXEL_DEPTH bits each
//   VGA_HS/VGA_VS             in   positive-polarity sync pulses
//   pix_data                  out  {R,G,B} of the captured pixel
//   pix_valid                 out  pix_data/pix_x/pix_y carry an active pixel
//   pix_x/pix_y               out  active-area coordinates
//   frame_start               out  high with pixel (0,0) only
//   line_end                  out  high with the last pixel of each line
//   h_total/v_total           out  last measured line length / frame length
//   locked                    out  capture FSM is in LOCKED
//   timing_err                out  one-cycle pulse on a timing mismatch
module vga_capture #(
    parameter int PIXEL_DEPTH = 4,
    parameter int H_ACTIVE    = 800,
    parameter int H_START     = 184,
    parameter int H_TOTAL     = 1040,
    parameter int V_ACTIVE    = 600,
    parameter int V_START     = 29,
    parameter int V_TOTAL     = 666
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [PIXEL_DEPTH-1:0]     VGA_R,
    input  logic [PIXEL_DEPTH-1:0]     VGA_G,
    input  logic [PIXEL_DEPTH-1:0]     VGA_B,
    input  logic                       VGA_HS,
    input  logic                       VGA_VS,
    output logic [3*PIXEL_DEPTH-1:0]   pix_data,
    output logic                       pix_valid,
    output logic [10:0]                pix_x,
    output logic [9:0]                 pix_y,
    output logic                       frame_start,
    output logic                       line_end,
    output logic [10:0]                h_total,
    output logic [9:0]                 v_total,
    output logic                       locked,
    output logic                       timing_err
);

    localparam logic [11:0] H_BEG     = 12'(H_START);
    localparam logic [11:0] H_END     = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] V_BEG     = 11'(V_START);
    localparam logic [10:0] V_END     = 11'(V_START + V_ACTIVE);
    localparam logic [10:0] H_START_L = 11'(H_START);
    localparam logic [9:0]  V_START_L = 10'(V_START);
    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
    localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // Saturating increments: the counters and the measured totals stick at
    // all-ones rather than wrapping, so a dead sync line cannot alias a
    // plausible length.
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // ---------------- stage 1: input registers ----------------
    logic [3*PIXEL_DEPTH-1:0] rgb_p1_q;
    logic                     hs_p1_q, vs_p1_q;
    logic                     hs_prev_q, vs_prev_q;
    logic [10:0]              hcount_q, hcount_d;
    logic [9:0]               vcount_q, vcount_d;
    logic                     hs_rise, vs_rise;

    assign hs_rise = hs_p1_q & ~hs_prev_q;
    assign vs_rise = vs_p1_q & ~vs_prev_q;

    // The counters are evaluated for the pixel sitting in stage 1, so the
    // HS-rise pixel itself is hcount 0; a VS rise overrides the line increment
    // so a coincident HS rise starts line 0.
    assign hcount_d = hs_rise ? 11'd0 : sat_inc11(hcount_q);
    assign vcount_d = vs_rise ? 10'd0 : (hs_rise ? sat_inc10(vcount_q) : vcount_q);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rgb_p1_q  <= '0;
            hs_p1_q   <= 1'b0;
            vs_p1_q   <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            hcount_q  <= '0;
            vcount_q  <= '0;
        end else begin
            rgb_p1_q  <= {VGA_R, VGA_G, VGA_B};
            hs_p1_q   <= VGA_HS;
            vs_p1_q   <= VGA_VS;
            hs_prev_q <= hs_p1_q;
            vs_prev_q <= vs_p1_q;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
        end
    end

    // Timing qualification of the stage-1 pixel.
    logic h_match, v_match, h_sat, line_bad, measure_ok, lock_fail;

    // hcount_q/vcount_q still hold the last pixel/line of the closing period.
    assign h_match    = (sat_inc11(hcount_q) == H_TOTAL_L);
    assign v_match    = (sat_inc10(vcount_q) == V_TOTAL_L);
    assign h_sat      = (hcount_d == 11'h7FF);
    assign line_bad   = (hs_rise & ~h_match) | h_sat;
    // The HS rise that coincides with the closing VS rise ends the last line
    // of the measured frame, so it is part of the verdict.
    assign measure_ok = h_ok_q & ~line_bad & v_match;
    assign lock_fail  = line_bad | (vs_rise & ~v_match);

    // ---------------- capture FSM ----------------
    state_t state_q, state_d;
    logic   h_ok_q, h_ok_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            h_ok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_ok_q  <= h_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_ok_d  = h_ok_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = MEASURE;
                    h_ok_d  = 1'b1;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    state_d = measure_ok ? LOCKED : MEASURE;
                    h_ok_d  = 1'b1;
                end else if (line_bad) begin
                    h_ok_d  = 1'b0;
                end
            end
            LOCKED: begin
                if (lock_fail) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    logic        err_d, valid_d, fs_d, le_d, active;
    logic [10:0] x_d;
    logic [9:0]  y_d;

    assign active = ({1'b0, hcount_d} >= H_BEG) && ({1'b0, hcount_d} < H_END) &&
                    ({1'b0, vcount_d} >= V_BEG) && ({1'b0, vcount_d} < V_END);

    always_comb begin
        err_d   = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            MEASURE: err_d = vs_rise & ~measure_ok;
            // The failing pixel is already suppressed, so nothing of a bad
            // line leaks out after the mismatch is seen.
            LOCKED: begin
                err_d   = lock_fail;
                valid_d = active & ~lock_fail;
            end
            default: ;
        endcase
        x_d  = valid_d ? (hcount_d - H_START_L) : 11'd0;
        y_d  = valid_d ? (vcount_d - V_START_L) : 10'd0;
        fs_d = valid_d && (x_d == 11'd0) && (y_d == 10'd0);
        le_d = valid_d && (x_d == X_LAST);
    end

    // ---------------- stage 2: output registers ----------------
    logic [3*PIXEL_DEPTH-1:0] pix_data_q;
    logic                     pix_valid_q, fs_q, le_q, locked_q, err_q;
    logic [10:0]              pix_x_q, h_total_q;
    logic [9:0]               pix_y_q, v_total_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            fs_q        <= 1'b0;
            le_q        <= 1'b0;
            h_total_q   <= '0;
            v_total_q   <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pix_data_q  <= rgb_p1_q;
            pix_valid_q <= valid_d;
            pix_x_q     <= x_d;
            pix_y_q     <= y_d;
            fs_q        <= fs_d;
            le_q        <= le_d;
            if (hs_rise) h_total_q <= sat_inc11(hcount_q);
            if (vs_rise) v_total_q <= sat_inc10(vcount_q);
            locked_q    <= (state_d == LOCKED);
            err_q       <= err_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = fs_q;
    assign line_end    = le_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign timing_err  = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced raster (16x8 total, 8x4 active)
// so that many frames fit in a short run.
module tb_vga_capture;

    localparam int HA  = 8;
    localparam int HST = 4;
    localparam int HT  = 16;
    localparam int VA  = 4;
    localparam int VST = 2;
    localparam int VT  = 8;

    logic        clk, rst;
    logic [3:0]  r, g, b;
    logic        hs, vs;
    logic [11:0] pix_data;
    logic        pix_valid, frame_start, line_end, locked, timing_err;
    logic [10:0] pix_x, h_total;
    logic [9:0]  pix_y, v_total;

    vga_capture #(
        .PIXEL_DEPTH(4), .H_ACTIVE(HA), .H_START(HST), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_START(VST), .V_TOTAL(VT)
    ) dut (
        .CLOCK_50(clk), .reset(rst),
        .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_end(line_end),
        .h_total(h_total), .v_total(v_total),
        .locked(locked), .timing_err(timing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int          n_valid = 0, n_fs = 0, n_le = 0, n_err = 0, n_incoh = 0;
    int          fs_cyc = 0;
    logic [11:0] fs_data = '0, le_data = '0;
    logic        err_pending = 1'b0, lock_after_err = 1'b1;

    always @(negedge clk) begin
        if (err_pending) begin
            lock_after_err = locked;
            err_pending    = 1'b0;
        end
        if (pix_valid) begin
            n_valid++;
            if (pix_data !== {pix_x[3:0], pix_y[3:0], 4'hA} ||
                pix_x >= 11'(HA) || pix_y >= 10'(VA))
                n_incoh++;
        end
        if (frame_start) begin
            n_fs++;
            fs_cyc  = cyc;
            fs_data = pix_data;
        end
        if (line_end) begin
            n_le++;
            le_data = pix_data;
        end
        if (timing_err) begin
            n_err++;
            err_pending = 1'b1;
        end
    end

    int n_chk = 0, n_pass = 0;
    int vs_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One input sample: k = clock within the line (HS rise at k=0),
    // l = line within the frame (VS rise at line 0, k=0).
    task automatic drive_sample(input int k, input int l);
        @(negedge clk);
        hs = (k < 2);
        vs = (l < 2);
        if (k >= HST && k < HST + HA && l >= VST && l < VST + VA) begin
            r = 4'(k - HST);
            g = 4'(l - VST);
            b = 4'hA;
        end else begin
            r = 4'h0; g = 4'h0; b = 4'h0;
        end
        if (k == 0 && l == 0) vs_cyc = cyc;
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = 1'b0; vs = 1'b0; r = 4'h0; g = 4'h0; b = 4'h0;
        end
    endtask

    task automatic drive_line(input int l, input int len);
        for (int k = 0; k < len; k++) drive_sample(k, l);
    endtask

    task automatic drive_frame(input int short_l);
        for (int l = 0; l < VT; l++) drive_line(l, (l == short_l) ? HT - 1 : HT);
    endtask

    int sv_valid, sv_fs, sv_le, sv_err;

    initial begin
        rst = 1'b1; hs = 1'b0; vs = 1'b0; r = 4'h0; g = 4'h0; b = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid",  32'(pix_valid), 0);
        check("rst_data",   32'(pix_data), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_totals", 32'({h_total, v_total}), 0);
        rst = 1'b0;

        // Nominal lock-up: first VS rise -> MEASURE, second -> LOCKED.
        drive_idle(5);
        drive_frame(-1);
        #1 check("lock_after_vs1", 32'(locked), 0);
        drive_frame(-1);
        #1 check("lock_after_vs2", 32'(locked), 1);

        // Third frame: full accounting and exact pixel latency.
        sv_valid = n_valid; sv_fs = n_fs; sv_le = n_le; sv_err = n_err;
        drive_frame(-1);
        #1;
        check("f3_valid",    32'(n_valid - sv_valid), HA * VA);
        check("f3_fstart",   32'(n_fs - sv_fs), 1);
        check("f3_lineend",  32'(n_le - sv_le), VA);
        check("f3_no_err",   32'(n_err - sv_err), 0);
        check("f3_h_total",  32'(h_total), HT);
        check("f3_v_total",  32'(v_total), VT);
        check("f3_fs_cycle", 32'(fs_cyc - vs_cyc), VST * HT + HST + 2);
        check("f3_fs_data",  32'(fs_data), 32'h00A);
        check("f3_le_data",  32'(le_data), 32'h73A);

        // Short line (15 clocks) at line 3 of a locked frame.
        sv_valid = n_valid; sv_err = n_err;
        drive_frame(3);
        #1;
        check("short_err_pulses", 32'(n_err - sv_err), 1);
        check("short_unlock",     32'(lock_after_err), 0);
        check("short_valid",      32'(n_valid - sv_valid), 2 * HA);
        check("short_locked",     32'(locked), 0);
        sv_valid = n_valid;
        drive_frame(-1);
        #1;
        check("relock_wait_valid",  32'(n_valid - sv_valid), 0);
        check("relock_wait_locked", 32'(locked), 0);
        sv_valid = n_valid;
        drive_frame(-1);
        #1;
        check("relock_locked", 32'(locked), 1);
        check("relock_valid",  32'(n_valid - sv_valid), HA * VA);

        // HS held low while locked: hcount saturation.
        sv_valid = n_valid; sv_err = n_err;
        drive_line(0, HT); drive_line(1, HT); drive_line(2, HT);
        drive_idle(2100);
        #1;
        check("hold_err_pulses", 32'(n_err - sv_err), 1);
        check("hold_locked",     32'(locked), 0);
        check("hold_h_total",    32'(h_total), HT);
        check("hold_valid",      32'(n_valid - sv_valid), HA);
        drive_frame(-1);
        drive_frame(-1);
        #1 check("hold_relock", 32'(locked), 1);

        // Asynchronous reset in the middle of an active line.
        drive_line(0, HT); drive_line(1, HT); drive_line(2, HT);
        for (int k = 0; k < 8; k++) drive_sample(k, 3);
        #1 check("pre_reset_valid", 32'(pix_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("async_flags",  32'({pix_valid, frame_start, line_end, locked, timing_err}), 0);
        check("async_data",   32'(pix_data), 0);
        check("async_xy",     32'({pix_x, pix_y}), 0);
        check("async_totals", 32'({h_total, v_total}), 0);
        for (int k = 8; k < 11; k++) drive_sample(k, 3);
        #1 rst = 1'b0;
        sv_valid = n_valid;
        for (int k = 11; k < HT; k++) drive_sample(k, 3);
        for (int l = 4; l < VT; l++) drive_line(l, HT);
        drive_frame(-1);
        #1;
        check("post_rst_valid",  32'(n_valid - sv_valid), 0);
        check("post_rst_vs1",    32'(locked), 0);
        drive_frame(-1);
        #1 check("post_rst_vs2", 32'(locked), 1);

        check("pixel_coherence", 32'(n_incoh), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
